// File: rtl/vram_arbiter_if.sv
// Bundles the three ports of the pixel RAM arbiter: the writer handshake, the
// single-port RAM port and the display pixel output.
// Writer handshake: i_Wr_Req is held with i_Wr_Addr/i_Wr_Data stable until a
// cycle in which o_Wr_Ack is high. That cycle consumes the request, either as a
// write or as an error drop flagged by o_Wr_Err. The writer drops i_Wr_Req the
// cycle after the ack unless it presents a new address/data pair.
interface vram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  // Writer side
  logic              i_Wr_Req;
  logic [ADDR_W-1:0] i_Wr_Addr;
  logic [DATA_W-1:0] i_Wr_Data;
  logic              o_Wr_Ack;
  logic              o_Wr_Err;
  // RAM side
  logic              o_Mem_En;
  logic              o_Mem_We;
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic [DATA_W-1:0] o_Mem_WData;
  logic [DATA_W-1:0] i_Mem_RData;
  // Display side
  logic [DATA_W-1:0] o_Pixel;
  logic              o_Pixel_Valid;
  // Arbiter FSM state: 0 IDLE, 1 DISP, 2 WRITE, 3 GUARD
  logic [1:0]        o_Dbg_State;

  modport slave (
    input  i_Wr_Req, i_Wr_Addr, i_Wr_Data, i_Mem_RData,
    output o_Wr_Ack, o_Wr_Err, o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_WData,
    output o_Pixel, o_Pixel_Valid, o_Dbg_State
  );

  modport master (
    output i_Wr_Req, i_Wr_Addr, i_Wr_Data, i_Mem_RData,
    input  o_Wr_Ack, o_Wr_Err, o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_WData,
    input  o_Pixel, o_Pixel_Valid, o_Dbg_State
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port pixel RAM (1-cycle read latency) between
// VGA scan-out and a pixel writer. Display reads own the RAM during active video.
// Writes are granted only in blanking, outside the guard columns that precede
// an active line. Counts at cycle N give the RAM access at N+1 and the pixel at N+2.
// Optional feature macro: VRAM_ARB_BURST_EN (back-to-back write grants). Without
// it, every write cycle is followed by one idle cycle before the next grant.
module vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int GUARD    = 2,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8
) (
  input  logic       CLK,
  input  logic       i_Rst_L,
  input  logic [9:0] i_CountCol,
  input  logic [9:0] i_CountRow,
  vram_arbiter_if.slave bus
);

`ifdef VRAM_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] H_TOT     = 10'(H_TOTAL);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_TOT     = 10'(V_TOTAL);
  localparam logic [9:0] GUARD_COL = 10'(H_TOTAL - GUARD);
  localparam logic [9:0] V_ACT_M1  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_TOT_M1  = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W:0]   PIX_TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DISP  = 2'd1,
    S_WRITE = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] scan_q, scan_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              pix_valid_q, pix_valid_d;

  logic              active;
  logic              in_range;
  logic              next_row_active;
  logic              guard;
  logic              frame_start;
  logic              wr_block;
  logic              addr_err;
  logic [ADDR_W-1:0] scan_use;

  // Classify the current counts and the writer request
  always_comb begin
    active          = (i_CountCol < H_ACT) && (i_CountRow < V_ACT);
    in_range        = (i_CountCol < H_TOT) && (i_CountRow < V_TOT);
    next_row_active = (i_CountRow < V_ACT_M1) || (i_CountRow == V_TOT_M1);
    guard           = in_range && (i_CountCol >= GUARD_COL) && next_row_active;
    frame_start     = (i_CountCol == 10'd0) && (i_CountRow == 10'd0);
    // Without burst, the cycle after a write is an enforced idle slot.
    wr_block        = !BURST && (state_q == S_WRITE);
    addr_err        = {1'b0, bus.i_Wr_Addr} >= PIX_TOTAL;
    // The first active pixel of a frame always reads address 0, whatever the
    // counter holds, so a counter disturbed by odd counts self-heals per frame.
    scan_use        = frame_start ? '0 : scan_q;
  end

  // Next state and next registered RAM/handshake outputs
  always_comb begin
    state_d     = S_IDLE;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    scan_d      = scan_use;
    pix_valid_d = (state_q == S_DISP);
    if (active) begin
      state_d    = S_DISP;
      mem_en_d   = 1'b1;
      mem_addr_d = scan_use;
      scan_d     = scan_use + ADDR_ONE;
    end else if (guard) begin
      state_d = S_GUARD;
    end else if (in_range && bus.i_Wr_Req && !wr_block) begin
      state_d = S_WRITE;
      ack_d   = 1'b1;
      if (addr_err) begin
        err_d = 1'b1;
      end else begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = bus.i_Wr_Addr;
        mem_wdata_d = bus.i_Wr_Data;
      end
    end
  end

  // State, scan counter and all registered outputs
  always_ff @(posedge CLK) begin
    if (!i_Rst_L) begin
      state_q     <= S_IDLE;
      scan_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign bus.o_Mem_En      = mem_en_q;
  assign bus.o_Mem_We      = mem_we_q;
  assign bus.o_Mem_Addr    = mem_addr_q;
  assign bus.o_Mem_WData   = mem_wdata_q;
  assign bus.o_Wr_Ack      = ack_q;
  assign bus.o_Wr_Err      = err_q;
  assign bus.o_Pixel_Valid = pix_valid_q;
  // Read data arrives the cycle after a display read; blanking is forced black.
  assign bus.o_Pixel       = pix_valid_q ? bus.i_Mem_RData : '0;
  assign bus.o_Dbg_State   = state_q;

endmodule
